// File: rtl/wm_neighbour_fetch.sv
// Neighbour fetch front end for the watermark insertion stage.
// For each raster pixel it presents the pixel itself, its left, upper and
// upper-left neighbours and one 2-bit watermark symbol. Border pixels (first
// row or first column) carry zero neighbours where none exist and symbol 00,
// and they do not consume a symbol.
module wm_neighbour_fetch #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int COL_W      = 6,
    parameter int ROW_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_pixel,
    input  logic       wm_valid,
    output logic       wm_ready,
    input  logic [7:0] wm_word,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] Data1,
    output logic [7:0] Data2,
    output logic [7:0] Data3,
    output logic [7:0] Data4,
    output logic [1:0] WM_Data,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    // Frame control and raster position
    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    // Packed symbol buffer: the active symbol always sits in bits [1:0]
    logic [7:0]       sym_q, sym_d;
    logic [2:0]       symCnt_q, symCnt_d;

    // One line of previous-row pixels, plus left / upper-left history
    logic [7:0]       lineBuf [IMG_WIDTH];
    logic [7:0]       left_q;
    logic [7:0]       upLeft_q;

    // Output register
    logic             outValid_q;
    logic [7:0]       data1_q, data2_q, data3_q, data4_q;
    logic [1:0]       wm_q;
    logic             frameDone_q;

    // Handshake and position decode
    logic             isBorder;
    logic             lastCol;
    logic             lastPixel;
    logic             pixAccept;
    logic             wmAccept;
    logic             outTake;
    logic             consumeSym;
    logic [7:0]       upRead;
    logic [7:0]       leftVal;
    logic [7:0]       upVal;
    logic [7:0]       upLeftVal;

    assign isBorder   = (row_q == '0) || (col_q == '0);
    assign lastCol    = (col_q == LAST_COL);
    assign lastPixel  = lastCol && (row_q == LAST_ROW);
    assign upRead     = lineBuf[col_q];

    // Input is taken only while running, when the output register can be
    // refilled this cycle, and when an interior pixel has a symbol to use.
    assign in_ready   = !rst && (state_q == ST_RUN)
                        && (!outValid_q || out_ready)
                        && (isBorder || (symCnt_q != 3'd0));
    assign wm_ready   = !rst && (symCnt_q == 3'd0);

    assign pixAccept  = in_valid && in_ready;
    assign wmAccept   = wm_valid && wm_ready;
    assign outTake    = outValid_q && out_ready;
    assign consumeSym = pixAccept && !isBorder;

    // Neighbour values, zeroed where the neighbour lies outside the frame
    assign leftVal    = (col_q == '0) ? 8'd0 : left_q;
    assign upVal      = (row_q == '0) ? 8'd0 : upRead;
    assign upLeftVal  = isBorder ? 8'd0 : upLeft_q;

    assign out_valid  = outValid_q;
    assign Data1      = data1_q;
    assign Data2      = data2_q;
    assign Data3      = data3_q;
    assign Data4      = data4_q;
    assign WM_Data    = wm_q;
    assign frame_done = frameDone_q;

    // Frame FSM next state and raster position advance
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_RUN: begin
                if (pixAccept) begin
                    if (lastPixel) begin
                        state_d = ST_DRAIN;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (lastCol) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (outTake) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Symbol buffer: reload a full word when empty, otherwise shift one out per interior pixel
    always_comb begin
        sym_d    = sym_q;
        symCnt_d = symCnt_q;
        if (wmAccept) begin
            sym_d    = wm_word;
            symCnt_d = 3'd4;
        end else if (consumeSym) begin
            sym_d    = {2'b00, sym_q[7:2]};
            symCnt_d = symCnt_q - 3'd1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            sym_q    <= '0;
            symCnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            sym_q    <= sym_d;
            symCnt_q <= symCnt_d;
        end
    end

    // Line buffer write; contents are never cleared since row 0 never reads them
    always_ff @(posedge clk) begin
        if (pixAccept) begin
            lineBuf[col_q] <= in_pixel;
        end
    end

    // Left and upper-left history, captured from the pixel being accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_q   <= 8'd0;
            upLeft_q <= 8'd0;
        end else if (pixAccept) begin
            left_q   <= lastCol ? 8'd0 : in_pixel;
            upLeft_q <= lastCol ? 8'd0 : upRead;
        end
    end

    // Output register: load on acceptance, hold while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            data1_q    <= 8'd0;
            data2_q    <= 8'd0;
            data3_q    <= 8'd0;
            data4_q    <= 8'd0;
            wm_q       <= 2'b00;
        end else if (pixAccept) begin
            outValid_q <= 1'b1;
            data1_q    <= in_pixel;
            data2_q    <= leftVal;
            data3_q    <= upVal;
            data4_q    <= upLeftVal;
            wm_q       <= isBorder ? 2'b00 : sym_q[1:0];
        end else if (outTake) begin
            outValid_q <= 1'b0;
        end
    end

    // Frame completion pulse, raised the cycle after the final output is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frameDone_q <= 1'b0;
        end else begin
            frameDone_q <= (state_q == ST_DRAIN) && outTake;
        end
    end

endmodule

// File: tb/tb_wm_neighbour_fetch.sv
// Randomised bench for wm_neighbour_fetch on a 4x3 image, checked against a
// frame-level model built from a pixel array and a symbol queue.
module tb_wm_neighbour_fetch;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_pixel = 8'd0;
    logic       wm_valid = 1'b0;
    logic       wm_ready;
    logic [7:0] wm_word = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] Data1, Data2, Data3, Data4;
    logic [1:0] WM_Data;
    logic       frame_done;

    typedef struct {
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] d3;
        logic [7:0] d4;
        logic [1:0] wm;
    } outRec_t;

    // Model state
    outRec_t    pend[$];
    outRec_t    outLog[$];
    logic [1:0] symQ[$];
    logic [7:0] pixQ[$];
    logic [7:0] wmQ[$];
    logic [7:0] img [0:H-1][0:W-1];
    int         phase;
    int         mRow, mCol;
    int         acceptedCnt;
    bit         expDone;
    bit         frameFinished;
    int         inRate, wmRate, readyMode;
    bit         startReq;
    int         assertCount = 0;
    int         failCount = 0;
    logic [7:0] w1;

    always #5 clk = ~clk;

    wm_neighbour_fetch #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (2),
        .ROW_W     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .wm_valid  (wm_valid),
        .wm_ready  (wm_ready),
        .wm_word   (wm_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Data1     (Data1),
        .Data2     (Data2),
        .Data3     (Data3),
        .Data4     (Data4),
        .WM_Data   (WM_Data),
        .frame_done(frame_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive this cycle's inputs from the pending queues and the rate knobs
    task automatic applyStimulus();
        in_valid = (pixQ.size() != 0) && ($urandom_range(0, 99) < inRate);
        in_pixel = (pixQ.size() != 0) ? pixQ[0] : 8'($urandom);
        wm_valid = (wmQ.size() != 0) && ($urandom_range(0, 99) < wmRate);
        wm_word  = (wmQ.size() != 0) ? wmQ[0] : 8'($urandom);
        if (readyMode == 0)      out_ready = 1'b1;
        else if (readyMode == 1) out_ready = ~out_ready;
        else                     out_ready = 1'($urandom_range(0, 1));
        start = startReq;
    endtask

    // One clock: drive, compare at the falling edge, advance the model, step past the rising edge
    task automatic runCycle();
        bit expInReady, takeOut, inAcc, wmAcc, startAcc, border;
        outRec_t rec, obs;
        applyStimulus();
        @(negedge clk);
        border = (mRow == 0) || (mCol == 0);
        expInReady = (phase == 1) && ((pend.size() == 0) || out_ready)
                     && (border || (symQ.size() != 0));
        checkOutput("in_ready", in_ready, expInReady);
        checkOutput("wm_ready", wm_ready, symQ.size() == 0);
        checkOutput("out_valid", out_valid, pend.size() != 0);
        checkOutput("frame_done", frame_done, expDone);
        if (pend.size() != 0) begin
            checkOutput("Data1", Data1, pend[0].d1);
            checkOutput("Data2", Data2, pend[0].d2);
            checkOutput("Data3", Data3, pend[0].d3);
            checkOutput("Data4", Data4, pend[0].d4);
            checkOutput("WM_Data", WM_Data, pend[0].wm);
        end
        takeOut  = (pend.size() != 0) && out_ready;
        inAcc    = in_valid && expInReady;
        wmAcc    = wm_valid && (symQ.size() == 0);
        startAcc = start && (phase == 0);
        expDone  = 1'b0;
        if (takeOut) begin
            obs.d1 = Data1; obs.d2 = Data2; obs.d3 = Data3; obs.d4 = Data4; obs.wm = WM_Data;
            outLog.push_back(obs);
            void'(pend.pop_front());
            if (phase == 2) begin
                phase = 0;
                expDone = 1'b1;
                frameFinished = 1'b1;
            end
        end
        if (inAcc) begin
            rec.d1 = in_pixel;
            rec.d2 = 8'd0; rec.d3 = 8'd0; rec.d4 = 8'd0; rec.wm = 2'b00;
            if (mCol != 0) rec.d2 = img[mRow][mCol-1];
            if (mRow != 0) rec.d3 = img[mRow-1][mCol];
            if (mRow != 0 && mCol != 0) rec.d4 = img[mRow-1][mCol-1];
            if (!border) rec.wm = symQ.pop_front();
            img[mRow][mCol] = in_pixel;
            pend.push_back(rec);
            void'(pixQ.pop_front());
            acceptedCnt++;
            if (mCol == W - 1) begin
                mCol = 0;
                if (mRow == H - 1) begin
                    mRow = 0;
                    phase = 2;
                end else begin
                    mRow++;
                end
            end else begin
                mCol++;
            end
        end
        if (wmAcc) begin
            symQ.push_back(wm_word[1:0]);
            symQ.push_back(wm_word[3:2]);
            symQ.push_back(wm_word[5:4]);
            symQ.push_back(wm_word[7:6]);
            void'(wmQ.pop_front());
        end
        if (startAcc) begin
            phase = 1;
            mRow = 0;
            mCol = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_Data1", Data1, 0);
        checkOutput("rst_Data2", Data2, 0);
        checkOutput("rst_Data3", Data3, 0);
        checkOutput("rst_Data4", Data4, 0);
        checkOutput("rst_WM_Data", WM_Data, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_wm_ready", wm_ready, 0);
        pend.delete();
        symQ.delete();
        pixQ.delete();
        phase = 0; mRow = 0; mCol = 0;
        expDone = 1'b0;
        startReq = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic startFrame();
        frameFinished = 1'b0;
        acceptedCnt = 0;
        startReq = 1'b1;
        runCycle();
        startReq = 1'b0;
    endtask

    task automatic runFrame(input int budget);
        int n = 0;
        while (!frameFinished && n < budget) begin
            runCycle();
            n++;
        end
        checkOutput("frame_timeout", frameFinished, 1);
    endtask

    task automatic loadPixels(input bit sequential);
        for (int i = 0; i < W * H; i++) begin
            if (sequential) pixQ.push_back(8'(i + 1));
            else            pixQ.push_back(8'($urandom));
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        phase = 0; mRow = 0; mCol = 0; acceptedCnt = 0;
        expDone = 1'b0; frameFinished = 1'b0; startReq = 1'b0;
        inRate = 100; wmRate = 100; readyMode = 0;
        #2;
        doReset();

        // No start: pixels offered but nothing accepted, buffer ready for a word
        $display("[TB] idle without start");
        loadPixels(0);
        repeat (3) runCycle();
        pixQ.delete();

        // Preloaded 8'hE4 and ramp pixels 1..12
        $display("[TB] ramp frame with E4 preload");
        wmQ.push_back(8'hE4);
        repeat (2) runCycle();
        wmQ.push_back(8'($urandom));
        loadPixels(1);
        outLog.delete();
        startFrame();
        runFrame(100);
        runCycle();
        checkOutput("ramp_count", outLog.size(), 12);
        checkOutput("p6_d1", outLog[5].d1, 6);
        checkOutput("p6_d2", outLog[5].d2, 5);
        checkOutput("p6_d3", outLog[5].d3, 2);
        checkOutput("p6_d4", outLog[5].d4, 1);
        checkOutput("p6_wm", outLog[5].wm, 0);
        checkOutput("p7_d1", outLog[6].d1, 7);
        checkOutput("p7_d2", outLog[6].d2, 6);
        checkOutput("p7_d3", outLog[6].d3, 3);
        checkOutput("p7_d4", outLog[6].d4, 2);
        checkOutput("p7_wm", outLog[6].wm, 1);
        checkOutput("p8_wm", outLog[7].wm, 2);
        checkOutput("p9_wm", outLog[8].wm, 0);
        checkOutput("p10_wm", outLog[9].wm, 3);
        checkOutput("p5_d2", outLog[4].d2, 0);

        // Symbol starvation: fifth interior pixel must wait for a second word
        $display("[TB] symbol starvation stall");
        doReset();
        wmQ.push_back(8'($urandom));
        repeat (2) runCycle();
        loadPixels(0);
        startFrame();
        repeat (30) runCycle();
        checkOutput("stall_in_ready", in_ready, 0);
        checkOutput("stall_out_valid", out_valid, 0);
        wmQ.push_back(8'($urandom));
        runFrame(100);
        runCycle();

        // Alternating downstream ready
        $display("[TB] toggling out_ready");
        readyMode = 1;
        wmQ.push_back(8'($urandom));
        wmQ.push_back(8'($urandom));
        loadPixels(0);
        outLog.delete();
        startFrame();
        runFrame(200);
        runCycle();
        checkOutput("toggle_count", outLog.size(), 12);

        // Reset in the middle of a frame, then a fresh randomised frame
        $display("[TB] mid-frame reset");
        readyMode = 0;
        inRate = 100;
        wmQ.push_back(8'($urandom));
        loadPixels(0);
        startFrame();
        for (int n = 0; n < 50 && acceptedCnt < 7; n++) runCycle();
        checkOutput("pre_reset_accepted", acceptedCnt, 7);
        doReset();
        wmQ.delete();
        wmQ.push_back(8'($urandom));
        wmQ.push_back(8'($urandom));
        readyMode = 2;
        inRate = 80;
        repeat (2) runCycle();
        loadPixels(0);
        startFrame();
        runFrame(300);
        runCycle();

        // Back-to-back frames with symbol carry-over
        $display("[TB] back-to-back frames");
        doReset();
        wmQ.delete();
        w1 = 8'($urandom);
        wmQ.push_back(8'($urandom));
        wmQ.push_back(w1);
        inRate = 75;
        repeat (3) runCycle();
        loadPixels(0);
        startFrame();
        runFrame(300);
        loadPixels(0);
        wmQ.push_back(8'($urandom));
        outLog.delete();
        startFrame();
        runFrame(300);
        runCycle();
        checkOutput("carry_symbol", outLog[5].wm, w1[5:4]);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
